// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers (read and write side).
package fifo_pkg;

  localparam int unsigned FIFO_AWIDTH = 4;
  localparam int unsigned DEPTH       = 2 ** FIFO_AWIDTH;

  // Pointers carry one extra wrap bit above the RAM address.
  typedef logic [FIFO_AWIDTH:0] ptr_t;

  // The conversions work on a wide container so that any pointer width can use them.
  // Leading zeros do not change either conversion.
  localparam int unsigned PtrMaxW = 32;
  typedef logic [PtrMaxW-1:0] ptr_max_t;

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[PtrMaxW-1] = gray[PtrMaxW-1];
    for (int k = PtrMaxW - 2; k >= 0; k--) begin
      bin[k] = bin[k+1] ^ gray[k];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module fifo_ptr_sync #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  // Plain flop chain: no logic between stages so each stage has a full cycle to resolve.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/flag controller of the dual-clock FIFO.
// Optional almost-empty flag and ALMOST_EMPTY_LVL parameter: define RD_ALMOST_EMPTY_EN.
module fifo_rd_ctrl #(
  parameter int unsigned AWIDTH      = fifo_pkg::FIFO_AWIDTH,
  parameter int unsigned SYNC_STAGES = 2
`ifdef RD_ALMOST_EMPTY_EN
  ,
  parameter int unsigned ALMOST_EMPTY_LVL = 2
`endif
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [AWIDTH:0] wr_pntr_gray_i,
  input  logic            rdreq_i,
  output logic [AWIDTH:0] rd_pntr_gray_o,
  output logic [AWIDTH-1:0] rd_addr_o,
  output logic            rd_en_o,
  output logic            rd_valid_o,
  output logic            empty_o,
  output logic [AWIDTH:0] rdusedw_o
`ifdef RD_ALMOST_EMPTY_EN
  ,
  output logic            almost_empty_o
`endif
);

  import fifo_pkg::*;

  typedef logic [AWIDTH:0] rptr_t;

  rptr_t wr_gray_s;
  rptr_t wr_bin_s;
  logic  acc;

  rptr_t rd_bin_q, rd_bin_d;
  rptr_t rd_gray_q, rd_gray_d;
  logic  empty_q, empty_d;
  rptr_t usedw_q, usedw_d;
  logic  rd_valid_q, rd_valid_d;

  fifo_ptr_sync #(
    .WIDTH       (AWIDTH + 1),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wr_ptr_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (wr_pntr_gray_i),
    .q_o     (wr_gray_s)
  );

  assign wr_bin_s = rptr_t'(gray2bin(ptr_max_t'(wr_gray_s)));

  always_comb begin
    acc        = rdreq_i & ~empty_q;
    rd_bin_d   = rd_bin_q + rptr_t'(acc);
    rd_gray_d  = rptr_t'(bin2gray(ptr_max_t'(rd_bin_d)));
    // Flags look at the post-read pointer so the last word read raises empty on its own edge.
    empty_d    = (rd_gray_d == wr_gray_s);
    usedw_d    = wr_bin_s - rd_bin_d;
    rd_valid_d = acc;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_bin_q   <= '0;
      rd_gray_q  <= '0;
      empty_q    <= 1'b1;
      usedw_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_bin_q   <= rd_bin_d;
      rd_gray_q  <= rd_gray_d;
      empty_q    <= empty_d;
      usedw_q    <= usedw_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef RD_ALMOST_EMPTY_EN
  logic almost_empty_q, almost_empty_d;

  assign almost_empty_d = (usedw_d <= rptr_t'(ALMOST_EMPTY_LVL));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      almost_empty_q <= 1'b1;
    end else begin
      almost_empty_q <= almost_empty_d;
    end
  end

  assign almost_empty_o = almost_empty_q;
`endif

  assign rd_pntr_gray_o = rd_gray_q;
  assign rd_addr_o      = rd_bin_q[AWIDTH-1:0];
  assign rd_en_o        = acc;
  assign rd_valid_o     = rd_valid_q;
  assign empty_o        = empty_q;
  assign rdusedw_o      = usedw_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a RAM model and a data scoreboard.
module tb_fifo_rd_ctrl;

  logic       clk;
  logic       rst_n_i;
  logic [4:0] wr_pntr_gray_i;
  logic       rdreq_i;
  logic [4:0] rd_pntr_gray_o;
  logic [3:0] rd_addr_o;
  logic       rd_en_o;
  logic       rd_valid_o;
  logic       empty_o;
  logic [4:0] rdusedw_o;
`ifdef RD_ALMOST_EMPTY_EN
  logic       almost_empty_o;
`endif

  fifo_rd_ctrl #(
    .AWIDTH      (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n_i),
    .wr_pntr_gray_i (wr_pntr_gray_i),
    .rdreq_i        (rdreq_i),
    .rd_pntr_gray_o (rd_pntr_gray_o),
    .rd_addr_o      (rd_addr_o),
    .rd_en_o        (rd_en_o),
    .rd_valid_o     (rd_valid_o),
    .empty_o        (empty_o),
    .rdusedw_o      (rdusedw_o)
`ifdef RD_ALMOST_EMPTY_EN
    ,
    .almost_empty_o (almost_empty_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tb_mem [16];
  logic [7:0] ram_q;
  logic [7:0] sb_q [$];
  logic [4:0] wr_bin;
  logic [4:0] rd_n;
  logic [4:0] prev_gray;

  // RAM with one cycle of read latency, driven by the DUT's address/enable.
  always @(posedge clk) begin
    if (rd_en_o) ram_q <= tb_mem[rd_addr_o];
  end

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_word();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    tb_mem[wr_bin[3:0]] = d;
    sb_q.push_back(d);
    wr_bin = wr_bin + 5'd1;
    wr_pntr_gray_i = gray(wr_bin);
  endtask

  task automatic tick();
    logic [7:0] exp;
    @(posedge clk);
    #1;
    if (rd_valid_o) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        check("rd_data", 32'(ram_q), 32'(exp));
      end
    end
    if (rst_n_i) check("gray_one_bit", 32'($countones(rd_pntr_gray_o ^ prev_gray) <= 1), 1);
    prev_gray = rd_pntr_gray_o;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"}, 32'(empty_o), 1);
    check({tag, "_usedw"}, 32'(rdusedw_o), 0);
    check({tag, "_gray"}, 32'(rd_pntr_gray_o), 0);
    check({tag, "_valid"}, 32'(rd_valid_o), 0);
  endtask

  initial begin
    rst_n_i = 1'b0;
    wr_pntr_gray_i = '0;
    rdreq_i = 1'b0;
    wr_bin = '0;
    rd_n = '0;
    prev_gray = '0;
    ram_q = '0;

    tick();
    tick();
    check_reset_state("rst_hold");
    check("rst_rd_en", 32'(rd_en_o), 0);
    @(negedge clk);
    rst_n_i = 1'b1;
    tick();
    check_reset_state("rst_rel");

    // Fill: Gray 0->1->3->2, visible three edges after each change.
    wr_word();
    tick();
    check("fill_empty_e1", 32'(empty_o), 1);
    wr_word();
    tick();
    check("fill_empty_e2", 32'(empty_o), 1);
    wr_word();
    tick();
    check("fill_empty_e3", 32'(empty_o), 0);
    check("fill_usedw_e3", 32'(rdusedw_o), 1);
    tick();
    check("fill_usedw_e4", 32'(rdusedw_o), 2);
    tick();
    check("fill_usedw_e5", 32'(rdusedw_o), 3);

    // Drain with five requests: only three are accepted.
    rdreq_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("drain_rd_en", 32'(rd_en_o), 32'(i < 3));
      if (i < 3) check("drain_addr", 32'(rd_addr_o), 32'(i));
      tick();
      check("drain_valid", 32'(rd_valid_o), 32'(i < 3));
      check("drain_empty", 32'(empty_o), 32'(i >= 2));
      check("drain_usedw", 32'(rdusedw_o), (i < 3) ? 32'(2 - i) : 0);
    end
    rdreq_i = 1'b0;
    rd_n = 5'd3;
    tick();
    check("drain_valid_off", 32'(rd_valid_o), 0);

    // Wrap: three rounds of fill-to-full then drain; read pointer passes 31 -> 0.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 16; k++) begin
        wr_word();
        tick();
      end
      tick();
      tick();
      check("full_usedw", 32'(rdusedw_o), 16);
      check("full_empty", 32'(empty_o), 0);
      rdreq_i = 1'b1;
      for (int k = 0; k < 16; k++) begin
        #1;
        check("wrap_addr", 32'(rd_addr_o), 32'(rd_n[3:0]));
        tick();
        rd_n = rd_n + 5'd1;
        check("wrap_gray", 32'(rd_pntr_gray_o), 32'(gray(rd_n)));
      end
      rdreq_i = 1'b0;
      check("wrap_empty", 32'(empty_o), 1);
      check("wrap_usedw", 32'(rdusedw_o), 0);
      tick();
    end

    // Concurrent: a write lands in the cycle that reads the last word.
    wr_word();
    repeat (3) tick();
    check("conc_usedw_pre", 32'(rdusedw_o), 1);
    rdreq_i = 1'b1;
    wr_word();
    #1;
    check("conc_rd_en", 32'(rd_en_o), 1);
    check("conc_addr0", 32'(rd_addr_o), 32'(rd_n[3:0]));
    tick();
    rdreq_i = 1'b0;
    rd_n = rd_n + 5'd1;
    check("conc_empty_b", 32'(empty_o), 1);
    tick();
    check("conc_empty_c", 32'(empty_o), 1);
    tick();
    check("conc_empty_d", 32'(empty_o), 0);
    check("conc_usedw_d", 32'(rdusedw_o), 1);
    rdreq_i = 1'b1;
    #1;
    check("conc_addr1", 32'(rd_addr_o), 32'(rd_n[3:0]));
    tick();
    rdreq_i = 1'b0;
    rd_n = rd_n + 5'd1;
    check("conc_empty_end", 32'(empty_o), 1);
    tick();

`ifdef RD_ALMOST_EMPTY_EN
    for (int k = 0; k < 3; k++) begin
      wr_word();
      tick();
    end
    tick();
    tick();
    check("ae_lvl3", 32'(almost_empty_o), 0);
    for (int k = 0; k < 3; k++) begin
      rdreq_i = 1'b1;
      tick();
      rdreq_i = 1'b0;
      rd_n = rd_n + 5'd1;
      check("ae_lvl_dn", 32'(almost_empty_o), 1);
    end
    tick();
`endif

    // Reset while a read is in progress.
    for (int k = 0; k < 3; k++) begin
      wr_word();
      tick();
    end
    tick();
    tick();
    rdreq_i = 1'b1;
    tick();
    check("mid_valid_pre", 32'(rd_valid_o), 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_reset_state("mid_rst");
    rdreq_i = 1'b0;
    sb_q.delete();
    wr_bin = '0;
    wr_pntr_gray_i = '0;
    rd_n = '0;
    prev_gray = '0;
    tick();
    tick();
    @(negedge clk);
    rst_n_i = 1'b1;
    tick();
    check_reset_state("post_rst");
    wr_word();
    repeat (3) tick();
    check("post_usedw", 32'(rdusedw_o), 1);
    rdreq_i = 1'b1;
    #1;
    check("post_addr", 32'(rd_addr_o), 0);
    tick();
    rdreq_i = 1'b0;
    check("post_empty", 32'(empty_o), 1);
    tick();

    check("sb_drained", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side pointer and flag controller of the dual-clock FIFO. It sits in the read clock domain and is the counterpart of the write-side controller.
- Synchronises the write Gray pointer into the read domain and converts it to binary.
- Owns the read pointer in binary and Gray form.
- Drives the RAM read address and enable.
- Generates empty_o, fill level and read-data-valid.

Parameters:
AWIDTH, 4, RAM address width; FIFO depth 2**AWIDTH; pointers are AWIDTH+1 bits (extra wrap bit).
SYNC_STAGES, 2, flop stages on the incoming write Gray pointer; legal range 2..4.
ALMOST_EMPTY_LVL, 2, threshold for almost_empty_o (used only with the optional feature).

Ports:
clk_i  input  1  read-domain clock.
rst_n_i  input  1  asynchronous active-low reset.
wr_pntr_gray_i  input  AWIDTH+1  write pointer, Gray, from the write domain; asynchronous to clk_i.
rdreq_i  input  1  read request from the consumer.
rd_pntr_gray_o  output  AWIDTH+1  registered read pointer, Gray, to the write-domain synchroniser.
rd_addr_o  output  AWIDTH  RAM read address = rd_pntr_bin[AWIDTH-1:0].
rd_en_o  output  1  RAM read enable = accepted read (combinational).
rd_valid_o  output  1  RAM q valid; one cycle after an accepted read.
empty_o  output  1  FIFO empty, registered.
rdusedw_o  output  AWIDTH+1  words available to read, registered; 0..2**AWIDTH.
almost_empty_o  output  1  present only with RD_ALMOST_EMPTY_EN.

Behaviour:
- Clock and reset: one clock, clk_i. rst_n_i is asynchronous assert, active-low; deassertion is synchronised externally.
- Reset values:
  - all synchroniser flops 0; rd_pntr_bin 0.
  - rd_pntr_gray_o 0; rd_valid_o 0; rdusedw_o 0.
  - empty_o 1; almost_empty_o 1.
- Synchroniser:
  - wr_pntr_gray_i passes through SYNC_STAGES flops with no logic between them, giving wr_gray_s.
  - wr_bin_s = Gray-to-binary of wr_gray_s over all AWIDTH+1 bits: bit k = XOR of wr_gray_s[AWIDTH:k]. The MSB is included.
- Accept: acc = rdreq_i & ~empty_o.
  - rdreq_i while empty is ignored: no pointer change, rd_en_o = 0.
- Pointer update:
  - rd_bin_next = rd_pntr_bin + acc, modulo 2**(AWIDTH+1); wraps from all-ones to 0.
  - rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1).
  - Both are registered on the same edge.
  - rd_pntr_gray_o comes directly from a flop; it changes at most one bit per cycle.
- empty_o next = (rd_gray_next == wr_gray_s). Evaluated against the next read pointer, so the last word read asserts empty on the same edge that consumes it.
- rdusedw_o next = wr_bin_s - rd_bin_next, modulo 2**(AWIDTH+1).
- RAM timing: rd_addr_o and rd_en_o are valid in the acc cycle; rd_valid_o = acc delayed one cycle (RAM latency 1).
- Write-to-visibility latency: a write-pointer change reaches empty_o/rdusedw_o SYNC_STAGES+1 read clocks after it is stable at wr_pntr_gray_i.
- Simultaneous read and write-pointer advance: both are applied in one cycle. empty_o stays 0 if the new write pointer is ahead of rd_gray_next.
- Wrap: pointers that are equal in low bits but differ in MSB mean full. Full is not empty, and rdusedw_o = 2**AWIDTH.
- Reset mid-operation: state returns to reset values immediately.
  - Any RAM read in flight is discarded; rd_valid_o goes to 0.
  - The write side must be reset in the same event; this is a system requirement.

Optional Feature:
RD_ALMOST_EMPTY_EN
- Defined: port almost_empty_o exists, registered, next = (rdusedw_next <= ALMOST_EMPTY_LVL), reset 1.
- Undefined: the port, its flop and ALMOST_EMPTY_LVL comparison logic are absent. All other behaviour is identical.

Decomposition:
- Package fifo_pkg:
  - pointer typedef ptr_t = logic [AWIDTH:0].
  - functions bin2gray and gray2bin, with full-width conversion.
  - localparam DEPTH = 2**AWIDTH.
  - The write-side controller shares this package.
- Sub-module fifo_ptr_sync: parameterised by width and SYNC_STAGES, async active-low reset. It is reused by the write side for rd_pntr_gray_o.

Test Plan:
- Reset: assert rst_n_i mid-stream with AWIDTH=4 -> empty_o=1, rdusedw_o=0, rd_pntr_gray_o=0, rd_valid_o=0 immediately.
- Fill: step wr_pntr_gray_i through Gray 0→1→3→2 (3 writes), rdreq_i=0 -> empty_o falls 3 clocks after the first change (SYNC_STAGES=2); rdusedw_o reaches 3.
- Drain: from 3 words, hold rdreq_i=1 for 5 cycles -> exactly 3 rd_en_o pulses with rd_addr_o 0,1,2; rd_valid_o lags each by 1; empty_o=1 on the edge consuming word 2; extra requests are ignored.
- Wrap: with 16 writes and 16 reads repeated 3 times -> rd_pntr_gray_o changes exactly one bit per increment, including 11111→00000 in binary; rdusedw_o=16 when full.
- Concurrent: one write lands in the same cycle as reading the last word -> empty_o pulses no more than the sync latency, then rdusedw_o=1 with no lost or duplicated address.
- RD_ALMOST_EMPTY_EN with ALMOST_EMPTY_LVL=2: fill levels 3→2→1→0 -> almost_empty_o 0,1,1,1. Without the macro the build has no such port and the other tests pass unchanged.
